// File: rtl/ceyloniac_alu_muldiv.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops into a
// registered result, plus an iterative multiply/divide engine into HI/LO.
// Handshake: a request is taken when op_valid is high and busy is low at a
// rising edge; done pulses for one cycle once the accepted op's results are
// visible; busy stays high from accept of a mul/div until its completion edge.
module ceyloniac_alu_muldiv #(
   parameter int ALU_DATA_WIDTH = 32,
   parameter int SHAMT_WIDTH    = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      op_valid,
   input  logic [3:0]                alu_control,
   input  logic [ALU_DATA_WIDTH-1:0] alu_in_a,
   input  logic [ALU_DATA_WIDTH-1:0] alu_in_b,
   output logic                      busy,
   output logic                      done,
   output logic [ALU_DATA_WIDTH-1:0] alu_out,
   output logic                      zero,
   output logic                      overflow,
   output logic                      div_zero,
   output logic [ALU_DATA_WIDTH-1:0] hi,
   output logic [ALU_DATA_WIDTH-1:0] lo
);

   localparam int W = ALU_DATA_WIDTH;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   is_div_q, is_div_d;
   logic                   a_neg_q, a_neg_d;
   logic                   b_neg_q, b_neg_d;
   logic                   b_zero_q, b_zero_d;
   logic [W-1:0]           a_orig_q, a_orig_d;
   logic [W-1:0]           opnd_q, opnd_d;
   logic [2*W-1:0]         acc_q, acc_d;
   logic [W-1:0]           alu_out_q, alu_out_d;
   logic [W-1:0]           hi_q, hi_d;
   logic [W-1:0]           lo_q, lo_d;
   logic                   zero_q, zero_d;
   logic                   overflow_q, overflow_d;
   logic                   div_zero_q, div_zero_d;
   logic                   done_q, done_d;

   // single-cycle datapath signals
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [W-1:0]           add_res, sub_res, sc_res;
   logic                   sc_ovf;

   // multicycle engine signals
   logic [W-1:0]           a_mag, b_mag;
   logic [W:0]             mul_sum, rem_sh, div_diff;
   logic                   div_ok;
   logic [2*W-1:0]         step_acc, mul_fix;
   logic [W-1:0]           fin_hi, fin_lo;

   assign shamt   = alu_in_b[SHAMT_WIDTH-1:0];
   assign add_res = alu_in_a + alu_in_b;
   assign sub_res = alu_in_a - alu_in_b;

   // Single-cycle result and signed-overflow flag for the current opcode
   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (alu_control)
         OP_AND:  sc_res = alu_in_a & alu_in_b;
         OP_OR:   sc_res = alu_in_a | alu_in_b;
         OP_ADD: begin
            sc_res = add_res;
            sc_ovf = (alu_in_a[W-1] == alu_in_b[W-1]) && (add_res[W-1] != alu_in_a[W-1]);
         end
         OP_XOR:  sc_res = alu_in_a ^ alu_in_b;
         OP_NOR:  sc_res = ~(alu_in_a | alu_in_b);
         OP_SUB: begin
            sc_res = sub_res;
            sc_ovf = (alu_in_a[W-1] != alu_in_b[W-1]) && (sub_res[W-1] != alu_in_a[W-1]);
         end
         OP_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(alu_in_a) < $signed(alu_in_b))};
         OP_SLTU: sc_res = {{(W-1){1'b0}}, (alu_in_a < alu_in_b)};
         OP_SLL:  sc_res = alu_in_a << shamt;
         OP_SRL:  sc_res = alu_in_a >> shamt;
         OP_SRA:  sc_res = $unsigned($signed(alu_in_a) >>> shamt);
         default: sc_res = '0;
      endcase
   end

   // Engine arithmetic: operand magnitudes, one shift-add / restoring-divide
   // step, and the final sign correction. acc holds {upper, lower} halves:
   // product/multiplier for mul, remainder/dividend-quotient for div.
   always_comb begin
      a_mag    = (~alu_control[0] & alu_in_a[W-1]) ? (~alu_in_a + 1'b1) : alu_in_a;
      b_mag    = (~alu_control[0] & alu_in_b[W-1]) ? (~alu_in_b + 1'b1) : alu_in_b;
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff = rem_sh - {1'b0, opnd_q};
      div_ok   = ~div_diff[W];
      if (is_div_q) begin
         step_acc = {(div_ok ? div_diff[W-1:0] : rem_sh[W-1:0]), acc_q[W-2:0], div_ok};
      end else begin
         step_acc = {mul_sum, acc_q[W-1:1]};
      end
      mul_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + 1'b1) : acc_q;
      if (is_div_q) begin
         if (b_zero_q) begin
            fin_hi = a_orig_q;
            fin_lo = '1;
         end else begin
            fin_hi = a_neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
            fin_lo = (a_neg_q ^ b_neg_q) ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
         end
      end else begin
         fin_hi = mul_fix[2*W-1:W];
         fin_lo = mul_fix[W-1:0];
      end
   end

   // Control FSM next-state and register updates
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      a_neg_d    = a_neg_q;
      b_neg_d    = b_neg_q;
      b_zero_d   = b_zero_q;
      a_orig_d   = a_orig_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      alu_out_d  = alu_out_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               if (alu_control[3:2] == 2'b11) begin
                  state_d  = ST_RUN;
                  cnt_d    = '0;
                  is_div_d = alu_control[1];
                  a_neg_d  = ~alu_control[0] & alu_in_a[W-1];
                  b_neg_d  = ~alu_control[0] & alu_in_b[W-1];
                  b_zero_d = (alu_in_b == '0);
                  a_orig_d = alu_in_a;
                  if (alu_control[1]) begin
                     opnd_d = b_mag;
                     acc_d  = {{W{1'b0}}, a_mag};
                  end else begin
                     opnd_d = a_mag;
                     acc_d  = {{W{1'b0}}, b_mag};
                  end
               end else begin
                  alu_out_d  = sc_res;
                  zero_d     = (sc_res == '0);
                  overflow_d = sc_ovf;
                  done_d     = 1'b1;
               end
            end
         end
         ST_RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHAMT_WIDTH'(W-1)) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d    = ST_IDLE;
            hi_d       = fin_hi;
            lo_d       = fin_lo;
            alu_out_d  = fin_lo;
            zero_d     = (fin_lo == '0);
            overflow_d = 1'b0;
            if (is_div_q) begin
               div_zero_d = b_zero_q;
            end
            done_d     = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         a_neg_q    <= 1'b0;
         b_neg_q    <= 1'b0;
         b_zero_q   <= 1'b0;
         a_orig_q   <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         alu_out_q  <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         a_neg_q    <= a_neg_d;
         b_neg_q    <= b_neg_d;
         b_zero_q   <= b_zero_d;
         a_orig_q   <= a_orig_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         alu_out_q  <= alu_out_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign alu_out  = alu_out_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_ceyloniac_alu_muldiv.sv
// Bench for ceyloniac_alu_muldiv: directed corner cases plus random ops,
// each checked against a plain-arithmetic reference model.
module tb_ceyloniac_alu_muldiv;

   localparam int W = 32;
   localparam longint S_MAX = 64'sd2147483647;
   localparam longint S_MIN = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          op_valid;
   logic [3:0]    alu_control;
   logic [W-1:0]  alu_in_a, alu_in_b;
   logic          busy, done, zero, overflow, div_zero;
   logic [W-1:0]  alu_out, hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   // expected architectural state
   logic [W-1:0]  e_out, e_hi, e_lo;
   logic          e_zero, e_ovf, e_dz;

   // clock
   always #5 clk = ~clk;

   ceyloniac_alu_muldiv #(.ALU_DATA_WIDTH(W), .SHAMT_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .alu_control(alu_control),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .busy(busy), .done(done),
      .alu_out(alu_out), .zero(zero), .overflow(overflow), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_alu_out"}, alu_out, e_out);
      chk({tag, "_zero"}, zero, e_zero);
      chk({tag, "_overflow"}, overflow, e_ovf);
      chk({tag, "_div_zero"}, div_zero, e_dz);
      chk({tag, "_hi"}, hi, e_hi);
      chk({tag, "_lo"}, lo, e_lo);
   endtask

   // reference model: results from integer arithmetic on the operands
   task automatic model_update(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, r, q, rm;
      logic [63:0] p;
      logic [4:0] sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = b[4:0];
      case (op)
         4'd0:  begin e_out = a & b; e_ovf = 1'b0; end
         4'd1:  begin e_out = a | b; e_ovf = 1'b0; end
         4'd2:  begin r = sa + sb; e_out = r[31:0]; e_ovf = (r > S_MAX) || (r < S_MIN); end
         4'd3:  begin e_out = a ^ b; e_ovf = 1'b0; end
         4'd4:  begin e_out = ~(a | b); e_ovf = 1'b0; end
         4'd5:  begin e_out = '0; e_ovf = 1'b0; end
         4'd6:  begin r = sa - sb; e_out = r[31:0]; e_ovf = (r > S_MAX) || (r < S_MIN); end
         4'd7:  begin e_out = (sa < sb) ? 32'd1 : 32'd0; e_ovf = 1'b0; end
         4'd8:  begin e_out = (a < b) ? 32'd1 : 32'd0; e_ovf = 1'b0; end
         4'd9:  begin e_out = a << sh; e_ovf = 1'b0; end
         4'd10: begin e_out = a >> sh; e_ovf = 1'b0; end
         4'd11: begin r = sa >>> sh; e_out = r[31:0]; e_ovf = 1'b0; end
         4'd12: begin p = sa * sb; e_hi = p[63:32]; e_lo = p[31:0]; end
         4'd13: begin p = {32'd0, a} * {32'd0, b}; e_hi = p[63:32]; e_lo = p[31:0]; end
         4'd14: begin
            if (b == 0) begin e_hi = a; e_lo = '1; e_dz = 1'b1; end
            else begin
               q = sa / sb; rm = sa % sb;
               e_lo = q[31:0]; e_hi = rm[31:0]; e_dz = 1'b0;
            end
         end
         default: begin
            if (b == 0) begin e_hi = a; e_lo = '1; e_dz = 1'b1; end
            else begin e_lo = a / b; e_hi = a % b; e_dz = 1'b0; end
         end
      endcase
      if (op >= 4'd12) begin
         e_out = e_lo;
         e_ovf = 1'b0;
      end
      e_zero = (e_out == 0);
   endtask

   // driver: issue one op, wait for completion, check everything
   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      model_update(op, a, b);
      @(negedge clk);
      op_valid = 1'b1; alu_control = op; alu_in_a = a; alu_in_b = b;
      @(posedge clk); #1;
      if (op >= 4'd12) begin
         chk({tag, "_busy_accept"}, busy, 1'b1);
         lat = 0;
         for (int k = 1; k <= W + 8; k++) begin
            // keep requesting garbage while busy; none may be taken
            @(negedge clk);
            op_valid = 1'b1;
            alu_control = 4'($urandom_range(0, 15));
            alu_in_a = $urandom; alu_in_b = $urandom;
            @(posedge clk); #1;
            if (done) begin
               lat = k;
               break;
            end
            chk({tag, "_busy_run"}, busy, 1'b1);
         end
         op_valid = 1'b0;
         chk({tag, "_latency"}, lat, W + 1);
         chk({tag, "_busy_done"}, busy, 1'b0);
      end else begin
         op_valid = 1'b0;
         chk({tag, "_done"}, done, 1'b1);
         chk({tag, "_busy"}, busy, 1'b0);
      end
      check_all(tag);
   endtask

   task automatic idle_cycle(input string tag);
      @(negedge clk);
      op_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_done_low"}, done, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; op_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e_out = '0; e_hi = '0; e_lo = '0; e_zero = 1'b0; e_ovf = 1'b0; e_dz = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // time limit
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rop;
      rst_n = 1'b0; op_valid = 1'b0; alu_control = '0; alu_in_a = '0; alu_in_b = '0;
      do_reset();

      // add/sub boundaries
      run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1);
      chk("add_ovf_lit_out", alu_out, 32'h8000_0000);
      chk("add_ovf_lit_flag", overflow, 1'b1);
      run_op("sub_zero", 4'd6, 32'd5, 32'd5);
      chk("sub_zero_lit", zero, 1'b1);
      run_op("sub_ovf", 4'd6, 32'h8000_0000, 32'd1);

      // compares and shifts
      run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'd1);
      chk("slt_lit", alu_out, 32'd1);
      run_op("sltu", 4'd8, 32'hFFFF_FFFF, 32'd1);
      chk("sltu_lit", alu_out, 32'd0);
      run_op("sra", 4'd11, 32'h8000_0000, 32'd4);
      chk("sra_lit", alu_out, 32'hF800_0000);
      run_op("rsvd", 4'd5, 32'h1234_5678, 32'h9ABC_DEF0);

      // multiply / divide
      run_op("mult", 4'd12, 32'hFFFF_FFFD, 32'd7);
      chk("mult_lit_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lit_lo", lo, 32'hFFFF_FFEB);
      run_op("multu", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div", 4'd14, 32'hFFFF_FFF9, 32'd2);
      chk("div_lit_lo", lo, 32'hFFFF_FFFD);
      chk("div_lit_hi", hi, 32'hFFFF_FFFF);
      run_op("divu_z", 4'd15, 32'd100, 32'd0);
      chk("divu_z_lit_hi", hi, 32'd100);
      chk("divu_z_lit_lo", lo, 32'hFFFF_FFFF);
      chk("divu_z_lit_flag", div_zero, 1'b1);
      run_op("div_min", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_z", 4'd14, 32'hFFFF_FF00, 32'd0);

      // back-to-back single-cycle ops, then done must drop
      run_op("b2b_and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
      run_op("b2b_or", 4'd1, 32'hF0F0_1234, 32'h0FF0_FF00);
      idle_cycle("b2b");

      // reset in the middle of a divide
      @(negedge clk);
      op_valid = 1'b1; alu_control = 4'd14; alu_in_a = 32'd1000; alu_in_b = 32'd7;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (10) @(posedge clk);
      do_reset();
      idle_cycle("post_rst");
      idle_cycle("post_rst2");

      // random ops
      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         run_op("rand", rop, pick_val(), pick_val());
         if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
